// File: rtl/ram_ws_pkg.sv
// Shared types and default parameter values for the wait-state RAM.
package ram_ws_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_WAIT   = 2;

endpackage

// File: rtl/ram_array.sv
// Plain storage: synchronous write, combinational read, no reset so contents survive Rst.
module ram_array
  import ram_ws_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge Clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ram_ws.sv
// Single-port RAM with a programmable number of wait states and a
// request / busy / valid handshake.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | ready; rd/wr sampled, access captured on acceptance
//   ST_WAIT | access in flight; cnt counts wait cycles, commit at WAIT
module ram_ws
  import ram_ws_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WAIT   = DEF_WAIT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  op_t               op_q;
  logic              commit;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign commit = (state == ST_WAIT) && (cnt == CNT_LAST);
  // Gating with Rst keeps a write from landing on an edge where reset aborts it.
  assign mem_we = commit && (op_q == OP_WR) && !Rst;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (rd || wr) state_nxt = ST_WAIT;
      ST_WAIT: if (commit)   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      data  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      valid <= 1'b0;
      if (state == ST_IDLE) begin
        if (rd || wr) begin
          addr_q  <= address;
          wdata_q <= wdata;
          op_q    <= wr ? OP_WR : OP_RD;
          cnt     <= CNT_ONE;
          busy    <= 1'b1;
        end
      end else if (commit) begin
        if (op_q == OP_RD) data <= mem_rdata;
        valid <= 1'b1;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  ram_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram_array (
    .Clk  (Clk),
    .we   (mem_we),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_ram_ws.sv
// Directed bench for ram_ws: default instance (8x256, WAIT=2) and a 16x16, WAIT=5 instance.
module tb_ram_ws;

  logic        Clk;
  logic        Rst;

  logic        a_rd, a_wr;
  logic [7:0]  a_address, a_wdata, a_data;
  logic        a_valid, a_busy;

  logic        b_rd, b_wr;
  logic [3:0]  b_address;
  logic [15:0] b_wdata, b_data;
  logic        b_valid, b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  ram_ws u_dut_a (
    .Clk(Clk), .Rst(Rst), .rd(a_rd), .wr(a_wr), .address(a_address),
    .wdata(a_wdata), .data(a_data), .valid(a_valid), .busy(a_busy)
  );

  ram_ws #(.DATA_W(16), .ADDR_W(4), .WAIT(5)) u_dut_b (
    .Clk(Clk), .Rst(Rst), .rd(b_rd), .wr(b_wr), .address(b_address),
    .wdata(b_wdata), .data(b_data), .valid(b_valid), .busy(b_busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_data;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on instance A; returns at #1 after the commit edge.
  task automatic a_access(input logic r, input logic w, input logic [7:0] ad,
                          input logic [7:0] wd, output int lat);
    @(negedge Clk);
    a_rd = r; a_wr = w; a_address = ad; a_wdata = wd;
    @(posedge Clk); #1;
    a_rd = 1'b0; a_wr = 1'b0;
    check("a busy after accept", {31'd0, a_busy}, 32'd1);
    lat = 0;
    while (lat < 20) begin
      @(posedge Clk); #1;
      lat++;
      if (a_valid) break;
    end
    check("a busy at commit", {31'd0, a_busy}, 32'd0);
  endtask

  task automatic b_access(input logic r, input logic w, input logic [3:0] ad,
                          input logic [15:0] wd, output int lat);
    @(negedge Clk);
    b_rd = r; b_wr = w; b_address = ad; b_wdata = wd;
    @(posedge Clk); #1;
    b_rd = 1'b0; b_wr = 1'b0;
    lat = 0;
    while (lat < 30) begin
      @(posedge Clk); #1;
      lat++;
      if (b_valid) break;
    end
  endtask

  vec_t vecs[12];
  int   lat;
  int   v1, v2, seen;

  initial begin
    Rst = 1'b1;
    a_rd = 1'b0; a_wr = 1'b0; a_address = '0; a_wdata = '0;
    b_rd = 1'b0; b_wr = 1'b0; b_address = '0; b_wdata = '0;

    vecs[0]  = '{1'b0, 1'b1, 8'd25, 8'h08, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'd25, 8'h00, 8'h08};
    vecs[2]  = '{1'b0, 1'b1, 8'd3,  8'hA5, 8'h08};
    vecs[3]  = '{1'b0, 1'b1, 8'd4,  8'h5A, 8'h08};
    vecs[4]  = '{1'b0, 1'b1, 8'd9,  8'h11, 8'h08};
    vecs[5]  = '{1'b0, 1'b1, 8'd7,  8'h00, 8'h08};
    vecs[6]  = '{1'b1, 1'b0, 8'd3,  8'h00, 8'hA5};
    vecs[7]  = '{1'b1, 1'b0, 8'd4,  8'h00, 8'h5A};
    vecs[8]  = '{1'b1, 1'b0, 8'd9,  8'h00, 8'h11};
    vecs[9]  = '{1'b1, 1'b1, 8'd7,  8'h3C, 8'h11};
    vecs[10] = '{1'b1, 1'b0, 8'd7,  8'h00, 8'h3C};
    vecs[11] = '{1'b0, 1'b1, 8'd0,  8'h77, 8'h3C};

    // reset then idle
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("idle data",  {24'd0, a_data},  32'd0);
      check("idle valid", {31'd0, a_valid}, 32'd0);
      check("idle busy",  {31'd0, a_busy},  32'd0);
    end

    // vector table, back-to-back on instance A
    for (int i = 0; i < 12; i++) begin
      a_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat);
      check("a latency", lat, 32'd2);
      check("a data", {24'd0, a_data}, {24'd0, vecs[i].exp_data});
    end
    a_access(1'b1, 1'b0, 8'd0, 8'h00, lat);
    check("a read 0 data", {24'd0, a_data}, 32'h77);

    // inputs ignored while busy
    @(negedge Clk);
    a_rd = 1'b1; a_address = 8'd3;
    @(posedge Clk); #1;
    a_rd = 1'b0;
    @(negedge Clk);
    a_address = 8'd4; a_wr = 1'b1; a_wdata = 8'hEE;
    @(posedge Clk); #1;
    a_wr = 1'b0;
    check("ign busy k+1",  {31'd0, a_busy},  32'd1);
    check("ign valid k+1", {31'd0, a_valid}, 32'd0);
    @(posedge Clk); #1;
    check("ign valid k+2", {31'd0, a_valid}, 32'd1);
    check("ign data k+2",  {24'd0, a_data},  32'hA5);
    @(posedge Clk); #1;
    check("ign no 2nd valid", {31'd0, a_valid}, 32'd0);
    a_access(1'b1, 1'b0, 8'd4, 8'h00, lat);
    check("ign addr4 kept", {24'd0, a_data}, 32'h5A);

    // reset mid-write
    @(negedge Clk);
    a_wr = 1'b1; a_address = 8'd9; a_wdata = 8'hFF;
    @(posedge Clk); #1;
    a_wr = 1'b0;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    check("rst busy",  {31'd0, a_busy},  32'd0);
    check("rst data",  {24'd0, a_data},  32'd0);
    seen = 0;
    repeat (5) begin
      @(posedge Clk); #1;
      if (a_valid) seen++;
    end
    check("rst no valid", seen, 32'd0);
    a_access(1'b1, 1'b0, 8'd9, 8'h00, lat);
    check("rst addr9 kept", {24'd0, a_data}, 32'h11);

    // reset and request on the same edge
    @(negedge Clk);
    Rst = 1'b1; a_rd = 1'b1; a_address = 8'd3;
    @(posedge Clk); #1;
    check("rst+req busy", {31'd0, a_busy}, 32'd0);
    Rst = 1'b0; a_rd = 1'b0;
    @(posedge Clk); #1;
    check("rst+req dropped", {31'd0, a_busy}, 32'd0);

    // parameter sweep instance: 16-bit, 16 words, WAIT=5
    b_access(1'b0, 1'b1, 4'd15, 16'hBEEF, lat);
    check("b write latency", lat, 32'd5);
    check("b write data", {16'd0, b_data}, 32'd0);
    b_access(1'b1, 1'b0, 4'd15, 16'h0000, lat);
    check("b read latency", lat, 32'd5);
    check("b read data", {16'd0, b_data}, 32'hBEEF);

    // held request: accepted at edge 1, valids at edges 6 and 12
    @(negedge Clk);
    b_rd = 1'b1; b_address = 4'd15;
    v1 = 0; v2 = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge Clk); #1;
      if (b_valid) begin
        if (v1 == 0) v1 = e;
        else if (v2 == 0) v2 = e;
      end
    end
    b_rd = 1'b0;
    check("b b2b first valid", v1, 32'd6);
    check("b b2b period", v2 - v1, 32'd6);
    check("b b2b data", {16'd0, b_data}, 32'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
